// File: rtl/reg_writeback_queue.sv
// In-order write-back queue feeding the register file write port; load requests win over ALU requests.
// Latency: an entry accepted at edge N reaches the head after edge N. Full refuses requests even on a
// popping cycle. The WB_FORWARD_EN macro adds youngest-match forwarding data for the Rs and Rd hazard lookups.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     aluValid,
  input  logic [ADDR_W-1:0]        aluReg,
  input  logic [DATA_W-1:0]        aluData,
  output logic                     aluReady,
  input  logic                     memValid,
  input  logic [ADDR_W-1:0]        memReg,
  input  logic [DATA_W-1:0]        memData,
  output logic                     memReady,
  input  logic                     changeEnable,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        writeRegister,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        Rs,
  input  logic [ADDR_W-1:0]        Rd,
  output logic                     rsPending,
  output logic                     rdPending,
`ifdef WB_FORWARD_EN
  output logic [DATA_W-1:0]        rsFwdData,
  output logic [DATA_W-1:0]        rdFwdData,
`endif
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_in_reg;
  logic [DATA_W-1:0] w_in_data;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Load path has fixed priority, so an ALU request is only taken when no load is offered.
  assign memReady  = !w_full;
  assign aluReady  = !w_full && !memValid;
  assign w_push    = (memValid && !w_full) || (aluValid && aluReady);
  assign w_in_reg  = memValid ? memReg  : aluReg;
  assign w_in_data = memValid ? memData : aluData;
  assign w_pop     = changeEnable && !w_empty;

  assign regWrite      = !w_empty;
  assign writeRegister = w_empty ? '0 : r_reg[r_head];
  assign writeData     = w_empty ? '0 : r_data[r_head];
  assign full          = w_full;
  assign empty         = w_empty;
  assign count         = r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_reg[r_tail]  <= w_in_reg;
        r_data[r_tail] <= w_in_data;
        r_tail         <= r_tail + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    rsPending = 1'b0;
    rdPending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_reg[i] == Rs)) rsPending = 1'b1;
      if (r_vld[i] && (r_reg[i] == Rd)) rdPending = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] w_slot;

  // Walk from oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    rsFwdData = '0;
    rdFwdData = '0;
    w_slot    = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = r_head + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if (r_reg[w_slot] == Rs) rsFwdData = r_data[w_slot];
        if (r_reg[w_slot] == Rd) rdFwdData = r_data[w_slot];
      end
    end
  end
`else
  // Without forwarding, decode relies on the pending flags alone.
`endif

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side counterpart of the 8x16 register file.
- Collects register write requests from the ALU result path and the memory-load path, buffers them in order, and issues at most one write per cycle on the register file's write port (regWrite / writeRegister / writeData), committing only on cycles where changeEnable is high.
- Provides per-register pending flags on the read addresses so decode can stall on read-after-write hazards.

Parameters:
- DEPTH, 4: queue entries; power of two, >= 2.
- DATA_W, 16: write data width.
- ADDR_W, 3: register index width (8 registers).

Ports:
- clock  in  1  single clock (p1 phase clock); all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- aluValid  in  1  ALU write request valid.
- aluReg  in  ADDR_W  ALU destination register.
- aluData  in  DATA_W  ALU write data.
- aluReady  out  1  ALU request accepted this edge when aluValid && aluReady.
- memValid  in  1  load write request valid.
- memReg  in  ADDR_W  load destination register.
- memData  in  DATA_W  load write data.
- memReady  out  1  load request accepted this edge when memValid && memReady.
- changeEnable  in  1  commit strobe; head is popped only when high.
- regWrite  out  1  head entry valid (to register file).
- writeRegister  out  ADDR_W  head destination.
- writeData  out  DATA_W  head data.
- Rs  in  ADDR_W  read address A (hazard lookup).
- Rd  in  ADDR_W  read address B (hazard lookup).
- rsPending  out  1  some queued entry targets Rs.
- rdPending  out  1  some queued entry targets Rd.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  log2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: circular buffer of {reg, data}; head/tail pointers wrap modulo DEPTH; count is tracked separately.
- Reset (reset==0, async): pointers = 0, count = 0, all entry valid bits cleared. Outputs: regWrite = 0, writeRegister = 0, writeData = 0, empty = 1, full = 0, pending = 0. Any in-flight entries are discarded and no write is issued.
- Ready:
  - memReady = !full.
  - aluReady = !full && !memValid.
  - Load path has fixed priority; at most one enqueue per edge.
  - Ready does not depend on changeEnable; a full queue refuses requests even on a popping cycle.
- Enqueue: written at tail on the rising edge; tail++.
- Write port is combinational from the head:
  - regWrite = !empty.
  - writeRegister / writeData = head entry.
  - Both forced to 0 when empty.
- Pop: on a rising edge with changeEnable && !empty, head++. The register file commits the same entry on that edge.
- Latency: a request accepted at edge N is presented at head no earlier than after edge N; there is no empty-queue bypass.
- Simultaneous pop and enqueue: count is unchanged, and both pointers advance.
- Ordering: strict FIFO. Multiple entries to the same register are allowed and drain oldest first.
- Pending: rsPending = OR over valid entries of (entry.reg == Rs); rdPending likewise for Rd. This is combinational and covers the head entry. r0 is an ordinary register (no hard-zero exclusion).
- changeEnable low: no pop. regWrite may remain high; the register file ignores it.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined: adds outputs rsFwdData and rdFwdData (DATA_W). Each carries the data of the youngest (most recently enqueued) valid entry matching Rs / Rd, or 0 if none matches. This lets decode bypass the register file instead of stalling.
- Undefined: these ports and the youngest-match logic are absent. Pending flags are unchanged.

Test Plan:
1. Queue holds 3 entries; reset driven 0 between clock edges -> count = 0, empty = 1, regWrite = 0 before the next edge. After reset returns to 1 and changeEnable = 1, no write is issued.
2. aluValid with r3 = 0x1234, then changeEnable = 1 -> regWrite = 1, writeRegister = 3, writeData = 0x1234 for exactly one cycle; empty = 1 after the popping edge.
3. memValid (r1, 0xAAAA) and aluValid (r2, 0x5555) in the same cycle -> aluReady = 0 and the load is enqueued; the ALU request is accepted next cycle. Drain order is r1/0xAAAA then r2/0x5555.
4. changeEnable = 0, 5 requests offered -> 4 accepted, then full = 1 and memReady = aluReady = 0 with the 5th held. One changeEnable pulse -> count = 3, full = 0, and the 5th is accepted next edge. Continue draining to verify pointer wrap-around preserves order.
5. Enqueue r5 = 0x00FF; drive Rs = 5, Rd = 4 -> rsPending = 1, rdPending = 0. After the pop, rsPending = 0.
6. (WB_FORWARD_EN) Enqueue r6 = 0x0001 then r6 = 0x0002; Rs = 6 -> rsFwdData = 0x0002. After one pop -> still 0x0002. After the second pop -> rsPending = 0, rsFwdData = 0.
